// File: rtl/cnn_acc_relu_sat.sv
// Accumulates N_TERMS signed products, adds bias, rescales with round-half-up,
// then applies ReLU and saturates into a non-negative OUT_W-bit result.
module cnn_acc_relu_sat #(
  parameter int PROD_W  = 24,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 14,
  parameter int N_TERMS = 9,
  parameter int SHIFT   = 8
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic signed [PROD_W-1:0] din,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic signed [PROD_W-1:0] bias,
  output logic        [OUT_W-1:0]  dout,
  output logic                     dout_valid,
  input  logic                     dout_ready
);

  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam int RSH   = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_W:0] ROUND_ONE = {{ACC_W{1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0] ROUND = (SHIFT > 0) ? (ROUND_ONE << RSH) : '0;
  localparam logic signed [ACC_W:0] MAXV  = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};

  typedef enum logic [1:0] {ACC, FIN, OUT} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic signed [ACC_W-1:0]   r_acc;
  logic        [CNT_W-1:0]   r_cnt;
  logic        [OUT_W-1:0]   r_dout;
  logic                      r_dout_valid;

  logic                      w_beat;
  logic                      w_last;
  logic signed [ACC_W-1:0]   w_din_ext;
  logic signed [ACC_W:0]     w_sum;
  logic signed [ACC_W:0]     w_shift;
  logic        [OUT_W-1:0]   w_result;

  // Ready is forced low while reset is held so nothing is taken during reset.
  assign din_ready  = (r_state == ACC) && !ap_rst;
  assign w_beat     = din_valid && din_ready;
  assign w_last     = (r_cnt == CNT_W'(N_TERMS - 1));
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

  assign w_din_ext = {{(ACC_W - PROD_W){din[PROD_W-1]}}, din};
  // One extra bit of headroom so bias and rounding can never wrap.
  assign w_sum   = {r_acc[ACC_W-1], r_acc}
                 + {{(ACC_W + 1 - PROD_W){bias[PROD_W-1]}}, bias}
                 + ROUND;
  assign w_shift = w_sum >>> SHIFT;

  always_comb begin
    w_result = w_shift[OUT_W-1:0];
    if (w_shift < 0) begin
      w_result = '0;
    end else if (w_shift > MAXV) begin
      w_result = MAXV[OUT_W-1:0];
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= ACC;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ACC:     if (w_beat && w_last) w_next = FIN;
      FIN:     w_next = OUT;
      OUT:     if (dout_ready) w_next = ACC;
      default: w_next = ACC;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      case (r_state)
        ACC: begin
          if (w_beat) begin
            r_acc <= r_acc + w_din_ext;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          end
        end
        FIN: begin
          r_dout       <= w_result;
          r_dout_valid <= 1'b1;
          r_acc        <= '0;
        end
        OUT: begin
          if (dout_ready) r_dout_valid <= 1'b0;
        end
        default: begin
          r_dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
